// File: rtl/seq_pkg.sv
// Shared types and encodings for the multi-cycle core sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       pc_we;
    logic       branch;
    logic       reg_we;
    logic       wb_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       busy;
  } ctl_t;

  // Moore strobes for a state; applied to the next state so they land in flops.
  function automatic ctl_t ctl_decode(state_e s, cls_e c);
    ctl_t k;
    k = '0;
    k.busy = (s != ST_IDLE) && (s != ST_TRAP);
    if (s == ST_EXEC || s == ST_MEM || s == ST_WB) begin
      k.alu_src = (c == CLS_I) || (c == CLS_LOAD) || (c == CLS_STORE);
      case (c)
        CLS_R:      k.alu_op = ALU_FUNCT;
        CLS_I:      k.alu_op = ALU_IFUNCT;
        CLS_BRANCH: k.alu_op = ALU_SUB;
        default:    k.alu_op = ALU_ADD;
      endcase
    end
    case (s)
      ST_FETCH: k.mem_req = 1'b1;
      ST_EXEC: begin
        k.pc_we  = (c == CLS_BRANCH);
        k.branch = (c == CLS_BRANCH);
      end
      ST_MEM: begin
        k.mem_req      = 1'b1;
        k.mem_addr_sel = 1'b1;
        k.mem_we       = (c == CLS_STORE);
      end
      ST_WB: begin
        k.reg_we = 1'b1;
        k.wb_sel = (c == CLS_LOAD);
        k.pc_we  = 1'b1;
      end
      default: ;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Shared memory port handshake between the sequencer and the memory arbiter.
interface core_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/seq_perf_counters.sv
// Active-cycle and retired-instruction counters, wrapping modulo 2^32.
module seq_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        pc_we,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + 32'(busy);
      instret_cnt <= instret_cnt + 32'(pc_we);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with shared memory port.
// Optional perf counters enabled by defining SEQ_PERF_COUNTERS_EN.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read on shared port, ir_load on ready
// DECODE | classify opcode, illegal -> TRAP
// EXEC   | ALU operation, branch retires here
// MEM    | load/store access, store retires on ready
// WB     | register write, PC+4
// TRAP   | sticky fault, left only by reset
module core_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [6:0]        opcode,
  input  logic              zero,
  core_sequencer_if.master  mem,
  output logic              ir_load,
  output logic              pc_we,
  output logic              pc_src,
  output logic              reg_we,
  output logic              wb_sel,
  output logic              alu_src,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state, state_nxt, boundary_st;
  cls_e              cls, cls_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [1:0]        cause_nxt;
  ctl_t              ctl;

  assign boundary_st = run ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_nxt = state;
    cls_nxt   = cls;
    wait_nxt  = '0;
    cause_nxt = trap_cause;
    case (state)
      ST_IDLE: if (run) state_nxt = ST_FETCH;
      ST_FETCH, ST_MEM: begin
        // ready on the final allowed cycle still completes the access
        if (mem.mem_ready) begin
          if (state == ST_FETCH)   state_nxt = ST_DECODE;
          else if (cls == CLS_LOAD) state_nxt = ST_WB;
          else                      state_nxt = boundary_st;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        state_nxt = ST_EXEC;
        case (opcode)
          OP_R:      cls_nxt = CLS_R;
          OP_I:      cls_nxt = CLS_I;
          OP_LOAD:   cls_nxt = CLS_LOAD;
          OP_STORE:  cls_nxt = CLS_STORE;
          OP_BRANCH: cls_nxt = CLS_BRANCH;
          default: begin
            state_nxt = ST_TRAP;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC: begin
        case (cls)
          CLS_BRANCH:          state_nxt = boundary_st;
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_WB:   state_nxt = boundary_st;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cls        <= CLS_R;
      wait_cnt   <= '0;
      ctl        <= '0;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state      <= state_nxt;
      cls        <= cls_nxt;
      wait_cnt   <= wait_nxt;
      ctl        <= ctl_decode(state_nxt, cls_nxt);
      trap       <= (state_nxt == ST_TRAP);
      trap_cause <= cause_nxt;
    end
  end

  assign mem.mem_req      = ctl.mem_req;
  assign mem.mem_we       = ctl.mem_we;
  assign mem.mem_addr_sel = ctl.mem_addr_sel;
  assign ir_load          = ctl.mem_req & ~ctl.mem_addr_sel & mem.mem_ready;
  // mem_we is only set in MEM for a store, so it doubles as the store-retire qualifier
  assign pc_we            = ctl.pc_we | (ctl.mem_we & mem.mem_ready);
  assign pc_src           = ctl.branch & zero;
  assign reg_we           = ctl.reg_we;
  assign wb_sel           = ctl.wb_sel;
  assign alu_src          = ctl.alu_src;
  assign alu_op           = ctl.alu_op;
  assign busy             = ctl.busy;

`ifdef SEQ_PERF_COUNTERS_EN
  seq_perf_counters u_perf (
    .clk         (clk),
    .rst_n       (reset),
    .busy        (busy),
    .pc_we       (pc_we),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench: per-cycle expectations built per instruction from the sequencing rules.
module tb_core_sequencer;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset, run, zero;
  logic [6:0]  opcode;
  logic        ir_load, pc_we, pc_src, reg_we, wb_sel, alu_src, busy, trap;
  logic [1:0]  alu_op, trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;

  core_sequencer_if mem_if ();

  core_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .opcode      (opcode),
    .zero        (zero),
    .mem         (mem_if),
    .ir_load     (ir_load),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .busy        (busy),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run, rdy, zero;
    logic [6:0] op;
    logic       req, we, asel, irl, pcwe, pcsrc, regwe, wbsel, alusrc, busy, trap;
    logic [1:0] aluop, cause;
  } cyc_t;

  cyc_t q[$];
  int   checks, failures, model_cyc, model_inst, pcwe_at, rec_idx;

  function automatic int exp_cnt(int v);
`ifdef SEQ_PERF_COUNTERS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic cyc_t blank(logic r, logic [6:0] op, logic z);
    cyc_t c;
    c = '{default: '0};
    c.run = r; c.op = op; c.zero = z; c.rdy = 1'b1;
    return c;
  endfunction

  function automatic cyc_t alu_fields(cyc_t c_in, logic [6:0] op);
    cyc_t c;
    c = c_in;
    c.alusrc = (op == OP_I) || (op == OP_LD) || (op == OP_ST);
    c.aluop  = (op == OP_R) ? 2'b10 : (op == OP_I) ? 2'b11 : (op == OP_BR) ? 2'b01 : 2'b00;
    return c;
  endfunction

  task automatic gen_idle(input logic r);
    q.push_back(blank(r, 7'h00, 1'b0));
  endtask

  task automatic gen_fetch(input logic [6:0] op, input int waits, input logic ra, input logic z);
    cyc_t c;
    for (int i = 0; i <= waits; i++) begin
      c = blank(ra, op, z);
      c.rdy = (i == waits); c.req = 1'b1; c.busy = 1'b1; c.irl = c.rdy;
      q.push_back(c);
    end
  endtask

  task automatic gen_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic z, input logic ra);
    cyc_t c;
    gen_fetch(op, fw, ra, z);
    c = blank(ra, op, z); c.busy = 1'b1;
    q.push_back(c);
    c = alu_fields(blank(ra, op, z), op); c.busy = 1'b1;
    if (op == OP_BR) begin c.pcwe = 1'b1; c.pcsrc = z; end
    q.push_back(c);
    if (op == OP_LD || op == OP_ST) begin
      for (int i = 0; i <= mw; i++) begin
        c = alu_fields(blank(ra, op, z), op);
        c.busy = 1'b1; c.req = 1'b1; c.asel = 1'b1; c.we = (op == OP_ST);
        c.rdy = (i == mw); c.pcwe = (op == OP_ST) && c.rdy;
        q.push_back(c);
      end
    end
    if (op != OP_BR && op != OP_ST) begin
      c = alu_fields(blank(ra, op, z), op);
      c.busy = 1'b1; c.regwe = 1'b1; c.wbsel = (op == OP_LD); c.pcwe = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic gen_trap(input logic [1:0] cause, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(1'b1, OP_BAD, 1'b0); c.trap = 1'b1; c.cause = cause;
      q.push_back(c);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s rec=%0d t=%0t actual=%0h expected=%0h", name, rec_idx, $time, act, exp);
    end
  endtask

  task automatic check_outputs(input cyc_t e);
    chk("mem_req",      32'(mem_if.mem_req),      32'(e.req));
    chk("mem_we",       32'(mem_if.mem_we),       32'(e.we));
    chk("mem_addr_sel", 32'(mem_if.mem_addr_sel), 32'(e.asel));
    chk("ir_load",      32'(ir_load),             32'(e.irl));
    chk("pc_we",        32'(pc_we),               32'(e.pcwe));
    chk("pc_src",       32'(pc_src),              32'(e.pcsrc));
    chk("reg_we",       32'(reg_we),              32'(e.regwe));
    chk("wb_sel",       32'(wb_sel),              32'(e.wbsel));
    chk("alu_src",      32'(alu_src),             32'(e.alusrc));
    chk("alu_op",       32'(alu_op),              32'(e.aluop));
    chk("busy",         32'(busy),                32'(e.busy));
    chk("trap",         32'(trap),                32'(e.trap));
    chk("trap_cause",   32'(trap_cause),          32'(e.cause));
    chk("cycle_cnt",    cycle_cnt,                32'(exp_cnt(model_cyc)));
    chk("instret_cnt",  instret_cnt,              32'(exp_cnt(model_inst)));
  endtask

  task automatic run_script();
    pcwe_at = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      run = q[i].run; mem_if.mem_ready = q[i].rdy; zero = q[i].zero; opcode = q[i].op;
      @(negedge clk);
      rec_idx = i;
      check_outputs(q[i]);
      if (pc_we === 1'b1 && pcwe_at < 0) pcwe_at = i;
      model_cyc  += int'(q[i].busy);
      model_inst += int'(q[i].pcwe);
    end
    q.delete();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0; run = 1'b0; mem_if.mem_ready = 1'b0;
    model_cyc = 0; model_inst = 0;
    #1;
    rec_idx = -1;
    check_outputs(blank(1'b0, 7'h00, 1'b0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; model_cyc = 0; model_inst = 0; rec_idx = -1;
    reset = 1'b0; run = 1'b0; zero = 1'b0; opcode = 7'h00; mem_if.mem_ready = 1'b0;
    #1;
    check_outputs(blank(1'b0, 7'h00, 1'b0));
    @(negedge clk);
    reset = 1'b1;

    // R-type, zero-wait memory: retires at cycle 4
    gen_idle(1'b1); gen_instr(OP_R, 0, 0, 1'b0, 1'b0); gen_idle(1'b0);
    chk("model_len_r", 32'(q.size()), 32'd6);
    run_script();
    chk("r_pcwe_cycle", 32'(pcwe_at), 32'd4);
    chk("r_cycle_cnt", cycle_cnt, 32'(exp_cnt(4)));
    chk("r_instret_cnt", instret_cnt, 32'(exp_cnt(1)));

    // LOAD with three MEM wait cycles: 8 cycles total
    gen_idle(1'b1); gen_instr(OP_LD, 0, 3, 1'b0, 1'b0); gen_idle(1'b0);
    chk("model_len_ld", 32'(q.size()), 32'd10);
    run_script();
    chk("ld_pcwe_cycle", 32'(pcwe_at), 32'd8);

    // back-to-back: beq taken, beq not taken, store with waits, I-type with run dropped
    gen_idle(1'b1);
    gen_instr(OP_BR, 0, 0, 1'b1, 1'b1);
    gen_instr(OP_BR, 0, 0, 1'b0, 1'b1);
    gen_instr(OP_ST, 2, 1, 1'b0, 1'b1);
    gen_instr(OP_I, 0, 0, 1'b1, 1'b0);
    gen_idle(1'b0);
    run_script();
    chk("br_pcwe_cycle", 32'(pcwe_at), 32'd3);

    // fetch ready on the 16th cycle still proceeds
    gen_idle(1'b1); gen_instr(OP_R, 15, 0, 1'b0, 1'b0); gen_idle(1'b0);
    run_script();
    chk("late_ready_pcwe_cycle", 32'(pcwe_at), 32'd19);

    // fetch timeout: request held 16 cycles then trap, run ignored
    gen_idle(1'b1); gen_fetch(OP_R, 15, 1'b1, 1'b0);
    q[q.size()-1].rdy = 1'b0; q[q.size()-1].irl = 1'b0;
    gen_trap(2'b10, 3);
    run_script();
    chk("timeout_cause", 32'(trap_cause), 32'd2);
    do_reset();

    // illegal opcode traps after DECODE
    gen_idle(1'b1); gen_fetch(OP_BAD, 0, 1'b1, 1'b0);
    q.push_back(blank(1'b1, OP_BAD, 1'b0)); q[q.size()-1].busy = 1'b1;
    gen_trap(2'b01, 3);
    run_script();
    chk("illegal_cause", 32'(trap_cause), 32'd1);
    do_reset();
    chk("trap_cleared", 32'(trap), 32'd0);

    // reset in the middle of a MEM wait, then restart from zeroed counters
    gen_idle(1'b1); gen_instr(OP_LD, 0, 5, 1'b0, 1'b1);
    while (q.size() > 6) void'(q.pop_back());
    run_script();
    chk("mid_mem_req", 32'(mem_if.mem_req), 32'd1);
    do_reset();
    gen_idle(1'b1); gen_instr(OP_R, 0, 0, 1'b0, 1'b0); gen_idle(1'b0);
    run_script();
    chk("restart_pcwe_cycle", 32'(pcwe_at), 32'd4);
    chk("restart_cycle_cnt", cycle_cnt, 32'(exp_cnt(4)));
    chk("restart_instret_cnt", instret_cnt, 32'(exp_cnt(1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RISC-V core datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It arbitrates one shared memory port between instruction fetch and load/store access using a req/ready handshake. It drives the PC, IR, register-file and ALU control strobes the datapath consumes in place of the single-cycle Control decoder.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles mem_req may wait for mem_ready before trapping.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- run  input  1  start/continue execution; sampled in IDLE and at instruction boundaries
- opcode  input  7  instruction[6:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the pending request this cycle
- mem_req  output  1  memory request
- mem_we  output  1  1 = store, 0 = read
- mem_addr_sel  output  1  0 = PC, 1 = ALU result
- ir_load  output  1  IR captures memory read data
- pc_we  output  1  PC update strobe
- pc_src  output  1  0 = PC+4, 1 = branch target
- reg_we  output  1  register-file write
- wb_sel  output  1  0 = ALU result, 1 = memory data
- alu_src  output  1  1 = immediate operand
- alu_op  output  2  00 add, 01 sub, 10 funct decode, 11 I-type funct decode
- busy  output  1  not in IDLE or TRAP
- trap  output  1  sticky trap flag
- trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout
- cycle_cnt  output  32  active-cycle counter
- instret_cnt  output  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE → FETCH when run=1.
- FETCH:
  - Outputs: mem_req=1, mem_we=0, mem_addr_sel=0.
  - ir_load = mem_ready.
  - On ready → DECODE.
- DECODE: one cycle. Classifies opcode: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH (beq). Any other opcode → TRAP, cause 01.
- EXEC:
  - alu_src and alu_op are driven per class in EXEC, MEM and WB.
  - R/I → WB.
  - BRANCH: pc_we=1, pc_src=zero, then boundary.
  - LOAD/STORE → MEM.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - On ready: LOAD → WB; STORE asserts pc_we (pc_src=0), then boundary.
- WB:
  - reg_we=1, wb_sel=1 for LOAD.
  - pc_we=1, pc_src=0, then boundary.
- Boundary (the cycle pc_we=1): next state is FETCH if run=1, otherwise IDLE. Dropping run mid-instruction always completes the current instruction.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable until a cycle with mem_req=1 and mem_ready=1.
  - mem_req drops the following cycle.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to FETCH/MEM and increments each non-ready cycle.
  - At TIMEOUT_CYCLES: mem_req drops, → TRAP, cause 10.
  - mem_ready in the same cycle as the count reaching the limit wins (no trap).
- TRAP: all strobes 0; trap=1 and trap_cause held until reset. The run input is ignored.
- Reset (any state, including mid-handshake): state IDLE, every output 0, counters 0, mem_req drops immediately.

## Timing
- All outputs are registered-state decodes: Moore outputs, except ir_load and the MEM-state pc_we, which are qualified by mem_ready.
- Latency with zero-wait memory (ready in the first request cycle):
  - R/I: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Exactly one pc_we pulse per retired instruction; none on trap.
- IDLE→FETCH takes 1 cycle after run is sampled high.

## Configuration
- SEQ_PERF_COUNTERS_EN defined:
  - cycle_cnt increments every cycle busy=1.
  - instret_cnt increments every cycle pc_we=1.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: both ports remain and are driven constant 0, so the datapath instantiation is unchanged.

## Structure
- Package seq_pkg holds:
  - the state enum;
  - opcode constants;
  - alu_op encodings;
  - trap_cause codes.
- Sub-module seq_perf_counters holds both counters. It is instantiated only under SEQ_PERF_COUNTERS_EN.

## Test plan
- R-type add, zero-wait memory, run=1: pc_we pulses at cycle 4 with reg_we=1, alu_op=10; instret_cnt=1, cycle_cnt=4.
- LOAD with mem_ready delayed 3 cycles in MEM: mem_req held stable for 4 cycles with mem_addr_sel=1; WB has wb_sel=1 and reg_we=1; total 8 cycles.
- beq with zero=1, then zero=0: pc_src=1, then pc_src=0; each asserts pc_we in EXEC at cycle 3; reg_we never asserted.
- Opcode 1111111: TRAP after DECODE, trap=1, cause=01; the next run pulse has no effect; reset clears trap and returns to IDLE.
- mem_ready held 0 in FETCH with TIMEOUT_CYCLES=16: mem_req drops after 16 cycles, trap_cause=10; a variant with ready on cycle 16 proceeds to DECODE instead.
- Reset asserted mid-MEM wait: all outputs 0 asynchronously; after release with run=1, FETCH restarts with counters at 0.
